// File: rtl/ifetch_queue_pkg.sv
// Shared core pipeline constants: fetch-queue defaults, instruction size and pointer sizing.
package ifetch_queue_pkg;

  localparam int unsigned IFQ_DEPTH    = 4;
  localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;
  localparam int unsigned ILEN_BYTES   = 4;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ifq_fifo_mem.sv
// Fetch-queue storage: one write port, one asynchronous read port, no reset on the array.
module ifq_fifo_mem
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = IFQ_DEPTH,
  parameter int unsigned PW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-limited fetch requests, in-order responses, redirect flush.
// Define IFETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the queue is empty.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned           WIDTH_DATA = 32,
  parameter int unsigned           WIDTH_ADDR = 32,
  parameter int unsigned           DEPTH      = IFQ_DEPTH,
  parameter logic [WIDTH_ADDR-1:0] RESET_PC   = WIDTH_ADDR'(IFQ_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect,
  input  logic [WIDTH_ADDR-1:0] redirect_pc,
  output logic                  mem_req,
  output logic [WIDTH_ADDR-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [WIDTH_DATA-1:0] mem_rdata,
  output logic                  instr_valid,
  output logic [WIDTH_DATA-1:0] instr,
  output logic [WIDTH_ADDR-1:0] instr_pc,
  output logic [WIDTH_ADDR-1:0] instr_pcplus4,
  input  logic                  instr_ready
);

  localparam int unsigned           PW      = ptr_width(DEPTH);
  localparam int unsigned           CW      = PW + 1;
  localparam int unsigned           EW      = WIDTH_DATA + WIDTH_ADDR;
  localparam logic [WIDTH_ADDR-1:0] STEP    = WIDTH_ADDR'(ILEN_BYTES);
  localparam logic [CW:0]           DEPTH_C = (CW + 1)'(DEPTH);

  logic [WIDTH_ADDR-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH_ADDR-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         discard_q, discard_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]         rd_entry;
  logic                  grant, resp_live, push, pop, bypass;

  // Credit: queued words plus outstanding requests never exceed the queue depth.
  assign mem_req  = rst_n & ~redirect & (({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_C);
  assign mem_addr = fetch_pc_q;
  assign grant    = mem_req & mem_gnt;

  // A response is kept only if it belongs to the current path.
  assign resp_live = mem_rvalid & ~redirect & (discard_q == '0);

  always_comb begin
    instr_valid = 1'b0;
    instr       = '0;
    instr_pc    = '0;
    bypass      = 1'b0;
    if (count_q != '0) begin
      instr_valid = 1'b1;
      instr       = rd_entry[WIDTH_DATA-1:0];
      instr_pc    = rd_entry[WIDTH_DATA +: WIDTH_ADDR];
    end
`ifdef IFETCH_QUEUE_BYPASS_EN
    else if (rst_n && resp_live && instr_ready) begin
      bypass      = 1'b1;
      instr_valid = 1'b1;
      instr       = mem_rdata;
      instr_pc    = resp_pc_q;
    end
`endif
  end

  assign instr_pcplus4 = instr_pc + STEP;

  assign pop  = instr_valid & instr_ready & ~redirect & ~bypass;
  assign push = resp_live & ~bypass;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    discard_d  = discard_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = inflight_q + CW'(grant) - CW'(mem_rvalid);
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~WIDTH_ADDR'(3);
      resp_pc_d  = redirect_pc & ~WIDTH_ADDR'(3);
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Everything still outstanding after this edge is old-path traffic.
      discard_d  = inflight_d;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + STEP;
      end
      if (mem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      if (resp_live) begin
        resp_pc_d = resp_pc_q + STEP;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  ifq_fifo_mem #(
    .WIDTH(EW),
    .DEPTH(DEPTH),
    .PW   (PW)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q),
    .wdata({resp_pc_q, mem_rdata}),
    .raddr(rd_ptr_q),
    .rdata(rd_entry)
  );

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CW'(DEPTH))));
  a_rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rvalid && (inflight_q == '0)));
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized scoreboard bench for ifetch_queue with an in-bench memory and path model.
module tb_ifetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;
  logic        instr_ready = 1'b0;

  always #5 clk = ~clk;

  ifetch_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_pcplus4(instr_pcplus4),
    .instr_ready  (instr_ready)
  );

  typedef struct {
    int unsigned ep;
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  pend_t       pend[$];     // requests the memory still owes, oldest first
  logic [31:0] fetched[$];  // current-path PCs fetched but not yet consumed
  int unsigned epoch, stale, cyc, grants, consumed;
  logic [31:0] exp_fetch;
  int unsigned p_gnt, p_rdy, p_redir, p_rv, lat_min, lat_max;
  int unsigned n_checks, n_fail;
  bit          armed;
  logic [31:0] first_after;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input bit ok, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: credit rule every cycle, and in-order scoreboard on each consumption.
  always @(negedge clk) begin : monitor
    bit          exp_req;
    logic [31:0] e;
    if (rst_n) begin
      exp_req = !redirect && ((fetched.size() + stale) < DEPTH);
      check("mem_req_credit", mem_req == exp_req, 32'(mem_req), 32'(exp_req));
      if (instr_valid && instr_ready && !redirect) begin
        if (fetched.size() == 0) begin
          check("spurious_instr", 1'b0, instr_pc, 32'hFFFF_FFFF);
        end else begin
          e = fetched.pop_front();
          check("instr_pc", instr_pc == e, instr_pc, e);
          check("instr_word", instr == word_of(e), instr, word_of(e));
          check("instr_pcplus4", instr_pcplus4 == e + 32'd4, instr_pcplus4, e + 32'd4);
          consumed++;
          if (armed) begin
            first_after = instr_pc;
            armed = 1'b0;
          end
        end
      end
    end
  end

  task automatic drive();
    pend_t h;
    mem_gnt     = ($urandom_range(0, 99) < p_gnt);
    instr_ready = ($urandom_range(0, 99) < p_rdy);
    redirect    = ($urandom_range(0, 99) < p_redir);
    redirect_pc = $urandom_range(0, 1023) << 2;
    mem_rvalid  = 1'b0;
    mem_rdata   = $urandom;
    if (pend.size() > 0) begin
      h = pend[0];
      if (h.due <= cyc && $urandom_range(0, 99) < p_rv) begin
        mem_rvalid = 1'b1;
        mem_rdata  = word_of(h.addr);
      end
    end
  endtask

  task automatic step();
    bit          g, rv, rd;
    logic [31:0] ga, rpc;
    pend_t       e;
    @(negedge clk);
    g   = mem_req && mem_gnt;
    ga  = mem_addr;
    rv  = mem_rvalid;
    rd  = redirect;
    rpc = redirect_pc;
    if (g) check("fetch_addr", ga == exp_fetch, ga, exp_fetch);
    @(posedge clk);
    #1;
    cyc++;
    if (rv && pend.size() > 0) pend.delete(0);
    if (g) begin
      e.ep   = epoch;
      e.addr = ga;
      e.due  = cyc + $urandom_range(lat_min, lat_max);
      pend.push_back(e);
      fetched.push_back(ga);
      exp_fetch = exp_fetch + 32'd4;
      grants++;
    end
    if (rd) begin
      epoch++;
      fetched.delete();
      exp_fetch   = rpc & ~32'h3;
      armed       = 1'b1;
      first_after = 32'hFFFF_FFFF;
    end
    stale = 0;
    foreach (pend[i]) if (pend[i].ep != epoch) stale++;
    drive();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    instr_ready = 1'b0;
    #1;
    check("rst_instr_valid", instr_valid == 1'b0, 32'(instr_valid), 32'd0);
    check("rst_mem_req", mem_req == 1'b0, 32'(mem_req), 32'd0);
    check("rst_instr", instr == 32'd0, instr, 32'd0);
    check("rst_mem_addr", mem_addr == RESET_PC, mem_addr, RESET_PC);
    pend.delete();
    fetched.delete();
    epoch++;
    stale     = 0;
    exp_fetch = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin : stimulus
    int unsigned c0, g0, k;
    bit          ok;
    n_checks = 0;
    n_fail   = 0;
    epoch    = 0;
    cyc      = 0;
    grants   = 0;
    consumed = 0;
    armed    = 1'b0;

    // Streaming from reset: PCs 0, 4, 8, ... one per cycle.
    p_gnt = 100; p_rdy = 100; p_redir = 0; p_rv = 100; lat_min = 0; lat_max = 0;
    do_reset();
    c0 = consumed;
    repeat (8) step();
    check("stream_throughput", (consumed - c0) >= 4, consumed - c0, 32'd4);

    // Decode stalled: exactly DEPTH grants, then requests stop; drain in order.
    p_rdy = 0;
    do_reset();
    g0 = grants;
    repeat (10) step();
    check("stall_grants", (grants - g0) == DEPTH, grants - g0, DEPTH);
    check("stall_req_low", mem_req == 1'b0, 32'(mem_req), 32'd0);
    check("stall_head_pc", instr_valid && instr_pc == RESET_PC, instr_pc, RESET_PC);
    p_rdy = 100; p_gnt = 0;
    instr_ready = 1'b1;
    mem_gnt     = 1'b0;
    c0 = consumed;
    repeat (6) step();
    check("stall_drain", (consumed - c0) == DEPTH, consumed - c0, DEPTH);

    // Redirect with 3 in flight, coinciding with a response and a pop.
    p_gnt = 100; p_rdy = 100; lat_min = 2; lat_max = 2;
    repeat (8) step();
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (pend.size() >= 3 && mem_rvalid && instr_valid && instr_ready) ok = 1'b1;
      else step();
    end
    check("redir_setup", ok, pend.size(), 32'd3);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    check("redir_mem_addr", mem_addr == 32'h100, mem_addr, 32'h100);
    check("redir_empty", instr_valid == 1'b0, 32'(instr_valid), 32'd0);
    repeat (15) step();
    check("redir_first_pc", first_after == 32'h100, first_after, 32'h100);

    // Randomized traffic with a mid-stream reset.
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        p_gnt   = $urandom_range(30, 100);
        p_rdy   = $urandom_range(20, 100);
        p_rv    = $urandom_range(40, 100);
        p_redir = $urandom_range(0, 5);
      end
      if (i == 1500) begin
        p_gnt = 100; p_rv = 0; p_redir = 0;
        k = 0;
        while (pend.size() < 2 && k < 20) begin
          step();
          k++;
        end
        check("midreset_inflight", pend.size() >= 2, pend.size(), 32'd2);
        p_rv = 100;
        do_reset();
      end
      step();
    end

    // Drain everything still outstanding.
    p_gnt = 0; p_rdy = 100; p_rv = 100; p_redir = 0;
    drive();
    repeat (40) step();
    check("drain_fetched", fetched.size() == 0, fetched.size(), 32'd0);
    check("drain_pending", pend.size() == 0, pend.size(), 32'd0);
    check("drain_valid", instr_valid == 1'b0, 32'(instr_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter WIDTH_DATA, default 32: instruction word width.
REQ-002 Parameter WIDTH_ADDR, default 32: PC and memory address width.
REQ-003 Parameter DEPTH, default 4: queue entries, power of two, minimum 2.
REQ-004 Parameter RESET_PC, default 32'h0000_0000: first fetch address.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 redirect  input  1  taken branch or jump from the execute stage.
REQ-008 redirect_pc  input  WIDTH_ADDR  branch or jump target.
REQ-009 mem_req  output  1  fetch request valid.
REQ-010 mem_addr  output  WIDTH_ADDR  fetch address, word aligned.
REQ-011 mem_gnt  input  1  memory accepts the request this cycle.
REQ-012 mem_rvalid  input  1  response valid; responses return in order, no earlier than the cycle after the grant.
REQ-013 mem_rdata  input  WIDTH_DATA  response instruction word.
REQ-014 instr_valid  output  1  queue head valid toward decode.
REQ-015 instr  output  WIDTH_DATA  head instruction.
REQ-016 instr_pc  output  WIDTH_ADDR  PC of the head instruction.
REQ-017 instr_pcplus4  output  WIDTH_ADDR  instr_pc + 4.
REQ-018 instr_ready  input  1  decode consumes the head this cycle; this is the inverse of the decode stall.

Function
REQ-019 A request is accepted on a cycle with mem_req & mem_gnt; on acceptance, fetch_pc advances by 4 (modulo 2^WIDTH_ADDR).
REQ-020 mem_addr shall equal fetch_pc; mem_req shall be 1 only when !redirect and (count + inflight) < DEPTH.
REQ-021 inflight counts accepted requests whose responses have not returned, including requests marked for discard; range 0..DEPTH.
REQ-022 A response with discard_cnt > 0 shall be dropped and shall decrement discard_cnt; otherwise the response shall be pushed with its PC taken from resp_pc, and resp_pc shall advance by 4.
REQ-023 A pop occurs when instr_valid & instr_ready; the head PC and instruction leave the queue.
REQ-024 A push and a pop in the same cycle shall leave count unchanged, including when the queue is full.
REQ-025 The credit rule in REQ-020 guarantees the queue never overflows; a push when the queue is full is a design error and shall trigger an assertion.
REQ-026 Read and write pointers shall wrap modulo DEPTH.
REQ-027 On redirect, the following shall happen at the next clock edge:
  - queue emptied and count set to 0;
  - fetch_pc and resp_pc set to redirect_pc;
  - discard_cnt set to inflight_next, the in-flight count after this cycle's grant and response;
  - any pop or push in the redirect cycle ignored.
REQ-028 A response arriving in the redirect cycle shall be dropped: it belongs to the old path, and discard_cnt_next excludes it.
REQ-029 A redirect arriving while discard_cnt > 0 shall recompute discard_cnt per REQ-027.
REQ-030 instr_valid shall be 0 whenever count == 0 (subject to the bypass in REQ-034).

Reset
REQ-031 While rst_n = 0, the following shall hold immediately:
  - fetch_pc = resp_pc = RESET_PC;
  - count, inflight and discard_cnt = 0;
  - pointers = 0;
  - instr_valid = 0, mem_req = 0, instr = 0.
REQ-032 mem_req may assert in the first cycle after rst_n rises.
REQ-033 A reset asserted mid-operation shall abandon all outstanding responses; the memory is reset by the same rst_n.

Configuration
REQ-034 With macro IFETCH_QUEUE_BYPASS_EN defined, when count == 0, mem_rvalid = 1, discard_cnt = 0, !redirect and instr_ready = 1:
  - mem_rdata and resp_pc shall drive the outputs combinationally, with instr_valid = 1;
  - the word shall not be written to the queue.
REQ-035 Without IFETCH_QUEUE_BYPASS_EN, every response is written to the queue and appears on the outputs one cycle after mem_rvalid, at the earliest.

Structure
REQ-036 RESET_PC default, DEPTH default and the pointer-width function shall live in the shared core package with the other pipeline constants.
REQ-037 Storage shall be a sub-module ifq_fifo_mem with one write port, one asynchronous read port and no reset on the data array; the counters and control stay in ifetch_queue.

Verification
REQ-038 Reset release, mem_gnt = 1, responses one cycle after each grant, instr_ready = 1 -> instr_pc = 0x0, 0x4, 0x8 on consecutive valid cycles; instr_pcplus4 = 0x4, 0x8, 0xC.
REQ-039 instr_ready = 0 for 10 cycles with DEPTH = 4 -> exactly 4 grants issued, then mem_req = 0; the queue holds PCs 0x0 to 0xC with no loss.
REQ-040 Redirect to 0x100 with 3 requests in flight -> those 3 responses are dropped and the next instr_valid carries instr_pc = 0x100.
REQ-041 Redirect in the same cycle as a response and a pop -> the response is dropped, count = 0 the next cycle, and mem_addr = redirect_pc.
REQ-042 Full queue with a simultaneous pop and push -> count stays 4 and the order is preserved.
REQ-043 rst_n pulsed low mid-stream with 2 requests in flight -> outputs reset immediately and fetch restarts at RESET_PC.
